cheat_code_loader: RTL and testbench

Upstream feeder for `geniecodes`. Takes cheat records streamed byte-wise from the MiSTer menu file download (HPS ioctl path), validates and assembles them, and emits the same 38-bit code strobes the Game Genie ROM path produces. Slot writes are serialized, so the code table can be filled without booting the Genie ROM. Its `code` output muxes with the `gamegenie` code output at the `geniecodes` input.

---
 rtl/nes_cheat_pkg.sv | 48 ++++
 rtl/cheat_record_asm.sv | 59 +++++
 rtl/cheat_code_loader.sv | 144 ++++++++++++++
 tb/tb_cheat_code_loader.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_cheat_pkg.sv
// Shared definitions for the NES cheat path: code word layout, record size and
// loader states. The Genie ROM decoder and the code table reuse the field positions.
package nes_cheat_pkg;

    localparam int CODE_W       = 38;
    localparam int STROBE_BIT   = 37;
    localparam int INDEX_HI     = 36;
    localparam int INDEX_LO     = 33;
    localparam int ENABLE_BIT   = 32;
    localparam int CMP_EN_BIT   = 31;
    localparam int ADDR_HI      = 30;
    localparam int ADDR_LO      = 16;
    localparam int COMPARE_HI   = 15;
    localparam int COMPARE_LO   = 8;
    localparam int REPLACE_HI   = 7;
    localparam int REPLACE_LO   = 0;

    localparam int RECORD_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        EMIT
    } state_e;

    typedef struct packed {
        logic        cmp_en;
        logic [14:0] addr;
        logic [7:0]  compare;
        logic [7:0]  replace;
    } cheat_rec_t;

    function automatic logic [CODE_W-1:0] pack_code(input logic [3:0] idx,
                                                    input logic en,
                                                    input cheat_rec_t rec);
        logic [CODE_W-1:0] c;
        c                          = '0;
        c[STROBE_BIT]              = 1'b1;
        c[INDEX_HI:INDEX_LO]       = idx;
        c[ENABLE_BIT]              = en;
        c[CMP_EN_BIT]              = rec.cmp_en;
        c[ADDR_HI:ADDR_LO]         = rec.addr;
        c[COMPARE_HI:COMPARE_LO]   = rec.compare;
        c[REPLACE_HI:REPLACE_LO]   = rec.replace;
        return c;
    endfunction

endpackage

// File: rtl/cheat_record_asm.sv
// Collects download bytes into 16-byte cheat records and flags each completed
// record as valid (PRG address) or bad in the cycle its last byte arrives.
module cheat_record_asm
    import nes_cheat_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       dl_start,
    input  logic       dl_wr,
    input  logic [7:0] dl_data,
    input  logic       dl_done,
    output logic       rec_valid,
    output logic       rec_bad,
    output cheat_rec_t rec
);

    localparam int CNT_W = $clog2(RECORD_BYTES);
    localparam int BUF_W = RECORD_BYTES * 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic             rec_done;
    logic             unused_bits;

    always_comb begin
        cnt_d = cnt_q;
        buf_d = buf_q;
        if (dl_wr && !dl_start) begin
            buf_d[{cnt_q, 3'b000} +: 8] = dl_data;
            cnt_d                       = cnt_q + 1'b1;
        end
        // A completing byte wraps the counter to 0 anyway, so done only drops partials.
        if (dl_start || dl_done) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            buf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            buf_q <= buf_d;
        end
    end

    // The final byte is replace[31:24], which is discarded, so fields come from buf_q alone.
    assign rec_done    = dl_wr && !dl_start && (cnt_q == CNT_W'(RECORD_BYTES - 1));
    assign rec.cmp_en  = buf_q[0];
    assign rec.addr    = buf_q[46:32];
    assign rec.compare = buf_q[71:64];
    assign rec.replace = buf_q[103:96];
    assign rec_valid   = rec_done && buf_q[47];
    assign rec_bad     = rec_done && !buf_q[47];

    assign unused_bits = ^{buf_q[31:1], buf_q[63:48], buf_q[95:72], buf_q[127:104]};

endmodule

// File: rtl/cheat_code_loader.sv
// Turns downloaded cheat records into geniecodes slot strobes: a clear sweep on
// dl_start, then one strobe per accepted record, all outputs registered.
module cheat_code_loader
    import nes_cheat_pkg::*;
#(
    parameter int MAX_CODES = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dl_start,
    input  logic              dl_wr,
    input  logic [7:0]        dl_data,
    input  logic              dl_done,
    output logic [CODE_W-1:0] code,
    output logic              busy,
    output logic [4:0]        code_count,
    output logic              overflow,
    output logic              bad_record
);

    localparam logic [4:0] MAX_W    = 5'(MAX_CODES);
    localparam logic [4:0] LAST_IDX = 5'(MAX_CODES - 1);

    logic              rec_valid, rec_bad;
    cheat_rec_t        rec;

    state_e            state_q, state_d;
    logic [4:0]        clr_idx_q, clr_idx_d;
    logic              pend_vld_q, pend_vld_d;
    cheat_rec_t        pend_q, pend_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              busy_q, busy_d;
    logic [4:0]        count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              bad_q, bad_d;
    logic              clr_strobe, take;
    cheat_rec_t        take_rec;

    cheat_record_asm u_asm (
        .clk       (clk),
        .reset     (reset),
        .dl_start  (dl_start),
        .dl_wr     (dl_wr),
        .dl_data   (dl_data),
        .dl_done   (dl_done),
        .rec_valid (rec_valid),
        .rec_bad   (rec_bad),
        .rec       (rec)
    );

    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        pend_vld_d = pend_vld_q;
        pend_d     = pend_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        bad_d      = bad_q;
        code_d     = '0;
        clr_strobe = 1'b0;
        take       = 1'b0;
        take_rec   = rec;

        case (state_q)
            CLEAR: begin
                code_d     = pack_code(clr_idx_q[3:0], 1'b0, '0);
                clr_strobe = 1'b1;
                clr_idx_d  = clr_idx_q + 5'd1;
                if (clr_idx_q == LAST_IDX) state_d = IDLE;
                if (rec_valid) begin
                    pend_vld_d = 1'b1;
                    pend_d     = rec;
                end
            end
            default: begin
                state_d = IDLE;
                if (pend_vld_q) begin
                    take       = 1'b1;
                    take_rec   = pend_q;
                    pend_vld_d = 1'b0;
                end else if (rec_valid) begin
                    take = 1'b1;
                end
            end
        endcase

        if (take) begin
            if (count_q == MAX_W) begin
                ovf_d = 1'b1;
            end else begin
                code_d  = pack_code(count_q[3:0], 1'b1, take_rec);
                count_d = count_q + 5'd1;
                state_d = EMIT;
            end
        end

        if (rec_bad) bad_d = 1'b1;

        // Slot 0 is strobed on the start edge itself so the sweep ends at t+MAX_CODES.
        if (dl_start) begin
            state_d    = (MAX_CODES > 1) ? CLEAR : IDLE;
            clr_idx_d  = 5'd1;
            code_d     = pack_code(4'd0, 1'b0, '0);
            clr_strobe = 1'b1;
            pend_vld_d = 1'b0;
            count_d    = '0;
            ovf_d      = 1'b0;
            bad_d      = 1'b0;
        end

        busy_d = clr_strobe || pend_vld_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            clr_idx_q  <= '0;
            pend_vld_q <= 1'b0;
            pend_q     <= '0;
            code_q     <= '0;
            busy_q     <= 1'b0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
            code_q     <= code_d;
            busy_q     <= busy_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            bad_q      <= bad_d;
        end
    end

    assign code       = code_q;
    assign busy       = busy_q;
    assign code_count = count_q;
    assign overflow   = ovf_q;
    assign bad_record = bad_q;

endmodule

// File: tb/tb_cheat_code_loader.sv
// Scoreboard bench for cheat_code_loader: stimulus pushes expected strobes with
// their due cycle, a negedge monitor pops and compares every strobe it sees.
module tb_cheat_code_loader;

    localparam int MAX = 9;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        dl_start   = 1'b0;
    logic        dl_wr      = 1'b0;
    logic [7:0]  dl_data    = 8'h00;
    logic        dl_done    = 1'b0;
    logic [37:0] code;
    logic        busy;
    logic [4:0]  code_count;
    logic        overflow;
    logic        bad_record;

    cheat_code_loader #(.MAX_CODES(MAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .dl_start   (dl_start),
        .dl_wr      (dl_wr),
        .dl_data    (dl_data),
        .dl_done    (dl_done),
        .code       (code),
        .busy       (busy),
        .code_count (code_count),
        .overflow   (overflow),
        .bad_record (bad_record)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [37:0] code;
    } exp_t;
    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    // Reference model state
    int         m_cnt = 0;
    int         m_count = 0;
    int         m_clear_end = -100;
    bit         m_ovf = 0;
    bit         m_bad = 0;
    logic [7:0] m_bytes[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_strobe: got none expected %0h at cycle %0d", e.code, e.cyc);
        end
        if (code[37] === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got %0h expected none (cycle %0d)", code, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_code", 64'(code), 64'(e.code));
                chk("strobe_cycle", 64'(cyc), 64'(e.cyc));
            end
        end else if (code !== 38'd0) begin
            checks++;
            errors++;
            $display("FAIL idle_code: got %0h expected 0 (cycle %0d)", code, cyc);
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
        dl_start = 1'b0;
        dl_wr    = 1'b0;
        dl_done  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) adv();
    endtask

    task automatic model_start();
        exp_t e;
        while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
        for (int i = 0; i < MAX; i++) begin
            e.cyc  = cyc + 1 + i;
            e.code = {1'b1, 4'(i), 33'd0};
            exp_q.push_back(e);
        end
        m_cnt       = 0;
        m_count     = 0;
        m_ovf       = 0;
        m_bad       = 0;
        m_clear_end = cyc + MAX;
    endtask

    task automatic model_byte(input logic [7:0] b);
        exp_t        e;
        logic [15:0] addr;
        m_bytes[m_cnt] = b;
        m_cnt++;
        if (m_cnt == 16) begin
            m_cnt = 0;
            addr  = {m_bytes[5], m_bytes[4]};
            if (!addr[15]) begin
                m_bad = 1;
            end else if (m_count == MAX) begin
                m_ovf = 1;
            end else begin
                e.cyc  = (cyc + 1 > m_clear_end + 1) ? cyc + 1 : m_clear_end + 1;
                e.code = {1'b1, 4'(m_count), 1'b1, m_bytes[0][0], addr[14:0], m_bytes[8], m_bytes[12]};
                exp_q.push_back(e);
                m_count++;
            end
        end
    endtask

    task automatic do_start(input bit with_byte, input logic [7:0] b);
        dl_start = 1'b1;
        if (with_byte) begin
            dl_wr   = 1'b1;
            dl_data = b;
        end
        model_start();
        adv();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit done);
        dl_wr   = 1'b1;
        dl_data = b;
        dl_done = done;
        model_byte(b);
        if (done) m_cnt = 0;
        adv();
    endtask

    task automatic send_rec(input logic [31:0] fl, input logic [31:0] ad, input logic [31:0] cp,
                            input logic [31:0] rp, input int gap_max, input bit done_last);
        logic [127:0] r;
        r = {rp, cp, ad, fl};
        for (int i = 0; i < 16; i++) begin
            send_byte(r[i*8 +: 8], done_last && (i == 15));
            if (gap_max > 0) idle($urandom_range(0, gap_max));
        end
    endtask

    task automatic send_rand_rec(input bit valid, input int gap_max, input bit done_last);
        logic [31:0] ad;
        ad     = $urandom;
        ad[15] = valid;
        send_rec($urandom, ad, $urandom, $urandom, gap_max, done_last);
    endtask

    task automatic chk_flags(input string tag);
        idle(2);
        chk({tag, "_count"}, 64'(code_count), 64'(m_count));
        chk({tag, "_overflow"}, 64'(overflow), 64'(m_ovf));
        chk({tag, "_bad"}, 64'(bad_record), 64'(m_bad));
    endtask

    initial begin
        int act;
        // Reset state
        idle(3);
        chk("reset_code", 64'(code), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_count", 64'(code_count), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        chk("reset_bad", 64'(bad_record), 64'd0);
        reset = 1'b0;
        idle(2);

        // Clear sweep with busy window
        do_start(0, 8'h00);
        for (int i = 0; i < MAX; i++) begin
            chk("sweep_busy", 64'(busy), 64'd1);
            adv();
        end
        chk("sweep_busy_end", 64'(busy), 64'd0);

        // Directed record, then a bad-address record
        send_rec(32'h1, 32'h0000D1DD, 32'h05, 32'h00, 0, 0);
        chk_flags("first_rec");
        send_rec(32'h1, 32'h00001234, 32'h05, 32'h00, 0, 0);
        chk_flags("bad_rec");

        // Fill the table and overflow
        do_start(0, 8'h00);
        idle(MAX + 1);
        for (int i = 0; i < 10; i++) send_rand_rec(1, 0, 0);
        chk_flags("overflow");

        // Partial record discarded by dl_done
        do_start(0, 8'h00);
        idle(MAX + 1);
        for (int i = 0; i < 7; i++) send_byte(8'($urandom), 0);
        dl_done = 1'b1;
        m_cnt   = 0;
        adv();
        send_rand_rec(1, 0, 0);
        chk_flags("partial");

        // dl_start coincident with byte 12 of a record in flight
        for (int i = 0; i < 12; i++) send_byte(8'($urandom), 0);
        do_start(1, 8'hA5);
        send_rand_rec(1, 0, 0);
        chk_flags("start_mid_rec");

        // dl_done on the final byte commits the record
        send_rand_rec(1, 1, 1);
        chk_flags("done_last");

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            act = $urandom_range(0, 99);
            if (act < 60) begin
                send_rand_rec($urandom_range(0, 4) != 0, $urandom_range(0, 2), 0);
            end else if (act < 75) begin
                for (int i = 0; i < $urandom_range(1, 15); i++) send_byte(8'($urandom), 0);
                send_byte(8'($urandom), 1);
            end else if (act < 88) begin
                do_start($urandom_range(0, 1), 8'($urandom));
            end else begin
                send_rand_rec(1, 0, 1);
            end
            idle($urandom_range(0, 3));
            if (n % 6 == 5) chk_flags("random");
        end
        chk_flags("random_end");

        // Reset in the middle of a sweep
        do_start(0, 8'h00);
        idle(3);
        reset = 1'b1;
        while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
        m_cnt       = 0;
        m_count     = 0;
        m_ovf       = 0;
        m_bad       = 0;
        m_clear_end = -100;
        adv();
        chk("midreset_code", 64'(code), 64'd0);
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_count", 64'(code_count), 64'd0);
        reset = 1'b0;
        idle(1);
        send_rand_rec(1, 0, 0);
        chk_flags("after_reset");

        idle(20);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
